// File: rtl/piso_pkg.sv
// Shared constants and state type for the 8-bit parallel-in/serial-out serializer.
package piso_pkg;

    localparam int unsigned SEL_W         = 3;
    localparam int unsigned BITS_PER_WORD = 8;

    localparam logic [SEL_W-1:0] LAST_CNT      = 3'd7;
    localparam logic [SEL_W-1:0] START_IDX_LSB = 3'd0;
    localparam logic [SEL_W-1:0] START_IDX_MSB = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] start_idx(input bit lsb_first);
        return lsb_first ? START_IDX_LSB : START_IDX_MSB;
    endfunction

endpackage

// File: rtl/piso_index_ctr.sv
// Beat counter and bit-select index for the serializer; loads on word accept,
// steps on each output beat and stops at the last bit without wrapping.
module piso_index_ctr
    import piso_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             active,
    output logic [SEL_W-1:0] cnt,
    output logic [SEL_W-1:0] sel,
    output logic             first,
    output logic             last
);

    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (load) begin
            cnt_d = '0;
            sel_d = start_idx(LSB_FIRST);
        end else if (step && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 3'd1;
            sel_d = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= start_idx(LSB_FIRST);
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign cnt   = cnt_q;
    assign sel   = sel_q;
    assign first = active & (cnt_q == '0);
    assign last  = active & (cnt_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer_8b.sv
// 8-bit parallel-in/serial-out stage: holds an accepted word and presents one
// selected bit per beat with valid/ready flow control and first/last framing.
module piso_serializer_8b
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [SEL_W-1:0]  cnt;
    logic              accept;
    logic              beat;
    logic              at_last;

    assign at_last = (cnt == LAST_CNT);

    // Ready also opens on the final beat so the next word follows with no bubble.
    assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == SHIFT) & at_last & ser_ready));
    assign accept    = in_valid & in_ready;
    assign ser_valid = (state_q == SHIFT);
    assign beat      = ser_valid & ser_ready;
    assign busy      = (state_q == SHIFT);
    assign ser_bit   = word_q[sel];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        if (accept) begin
            state_d = SHIFT;
            word_d  = in_data;
        end else if (beat && at_last) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    piso_index_ctr #(
        .LSB_FIRST (LSB_FIRST)
    ) u_index_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (beat),
        .active (ser_valid),
        .cnt    (cnt),
        .sel    (sel),
        .first  (ser_first),
        .last   (ser_last)
    );

endmodule

// File: tb/tb_piso_serializer_8b.sv
// Bench for piso_serializer_8b: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a frame/position model plus literal expectations.
module tb_piso_serializer_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic       d_in_ready  [2];
    logic       d_ser_bit   [2];
    logic       d_ser_valid [2];
    logic       d_ser_first [2];
    logic       d_ser_last  [2];
    logic       d_busy      [2];
    logic [2:0] d_sel       [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer_8b #(
        .DATA_W    (8),
        .LSB_FIRST (1'b1)
    ) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready[0]),
        .ser_bit   (d_ser_bit[0]),
        .ser_valid (d_ser_valid[0]),
        .ser_ready (ser_ready),
        .ser_first (d_ser_first[0]),
        .ser_last  (d_ser_last[0]),
        .sel       (d_sel[0]),
        .busy      (d_busy[0])
    );

    piso_serializer_8b #(
        .DATA_W    (8),
        .LSB_FIRST (1'b0)
    ) u_msb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready[1]),
        .ser_bit   (d_ser_bit[1]),
        .ser_valid (d_ser_valid[1]),
        .ser_ready (ser_ready),
        .ser_first (d_ser_first[1]),
        .ser_last  (d_ser_last[1]),
        .sel       (d_sel[1]),
        .busy      (d_busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a word plus a position k (0..7) within it; instance 0
    // maps position k to bit k, instance 1 maps it to bit 7-k.
    bit         m_active [2] = '{1'b0, 1'b0};
    int         m_k      [2] = '{0, 0};
    logic [7:0] m_word   [2] = '{8'h00, 8'h00};

    function automatic int bit_pos(input int i, input int k);
        return (i == 0) ? k : 7 - k;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_k[i]      <= 0;
                m_word[i]   <= 8'h00;
            end else begin
                if (m_active[i] && ser_ready) begin
                    if (m_k[i] == 7) m_active[i] <= 1'b0;
                    else             m_k[i] <= m_k[i] + 1;
                end
                if (in_valid && (!m_active[i] || (m_k[i] == 7 && ser_ready))) begin
                    m_word[i]   <= in_data;
                    m_k[i]      <= 0;
                    m_active[i] <= 1'b1;
                end
            end
        end
    end

    // Recorded beats and per-test statistics.
    logic [63:0] sb      [2];
    logic [2:0]  ss      [2][64];
    int          nb      [2];
    int          vcount  [2];
    int          run     [2];
    int          max_run [2];
    int          fcount  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic exp_ready;
            exp_ready = !rst && (!m_active[i] || (m_k[i] == 7 && ser_ready));
            chk($sformatf("ser_valid%0d", i), 32'(d_ser_valid[i]), 32'(m_active[i]));
            chk($sformatf("busy%0d", i),      32'(d_busy[i]),      32'(m_active[i]));
            chk($sformatf("in_ready%0d", i),  32'(d_in_ready[i]),  32'(exp_ready));
            chk($sformatf("sel%0d", i),       32'(d_sel[i]),       bit_pos(i, m_k[i]));
            chk($sformatf("ser_first%0d", i), 32'(d_ser_first[i]), 32'(m_active[i] && m_k[i] == 0));
            chk($sformatf("ser_last%0d", i),  32'(d_ser_last[i]),  32'(m_active[i] && m_k[i] == 7));
            if (m_active[i])
                chk($sformatf("ser_bit%0d", i), 32'(d_ser_bit[i]), 32'(m_word[i][bit_pos(i, m_k[i])]));

            if (d_ser_valid[i] === 1'b1 && ser_ready === 1'b1 && nb[i] < 64) begin
                sb[i][nb[i]] = d_ser_bit[i];
                ss[i][nb[i]] = d_sel[i];
                nb[i]++;
            end
            if (d_ser_valid[i] === 1'b1) begin
                vcount[i]++;
                run[i]++;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end else begin
                run[i] = 0;
            end
            if (d_ser_first[i] === 1'b1) fcount[i]++;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            sb[i] = '0; nb[i] = 0; vcount[i] = 0;
            run[i] = 0; max_run[i] = 0; fcount[i] = 0;
        end
    endtask

    function automatic logic [7:0] word_from(input int i, input int off);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[bit_pos(i, j)] = sb[i][off + j];
        return w;
    endfunction

    task automatic send(input logic [7:0] w);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            n++;
        end while (d_in_ready[0] !== 1'b1 && n < 20);
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never rose for %h", w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((d_busy[0] !== 1'b0 || d_busy[1] !== 1'b0) && n < 60);
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %b/%b", d_busy[0], d_busy[1]);
        end
    endtask

    initial begin
        int acc;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ser_ready = 1'b1;
        clear_stats();

        // Reset quiescence
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(d_in_ready[0]), 0);
        chk("rst_ser_valid", 32'(d_ser_valid[0]), 0);
        chk("rst_busy", 32'(d_busy[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(d_in_ready[0]), 1);
        chk("idle_sel_lsb", 32'(d_sel[0]), 0);
        chk("idle_sel_msb", 32'(d_sel[1]), 7);

        // Single word A5
        clear_stats();
        send(8'hA5);
        wait_idle();
        chk("a5_beats", nb[0], 8);
        chk("a5_stream", 32'(sb[0][7:0]), 32'h0000_00A5);
        chk("a5_word_msb", 32'(word_from(1, 0)), 32'h0000_00A5);
        for (int j = 0; j < 8; j++) chk($sformatf("a5_sel%0d", j), 32'(ss[0][j]), j);
        chk("a5_valid_cycles", vcount[0], 8);

        // Back-to-back A5, 3C with in_valid held
        clear_stats();
        acc = 0; n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hA5;
        while (acc < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (d_in_ready[0] === 1'b1) acc++;
            @(posedge clk); #1;
            if (acc == 1) in_data = 8'h3C;
            if (acc == 2) in_valid = 1'b0;
        end
        if (acc < 2) begin
            checks++; errors++;
            $display("FAIL b2b_accept: accepted %0d of 2", acc);
            in_valid = 1'b0;
        end
        wait_idle();
        chk("b2b_beats", nb[0], 16);
        chk("b2b_run", max_run[0], 16);
        chk("b2b_firsts", fcount[0], 2);
        chk("b2b_word0", 32'(word_from(0, 0)), 32'h0000_00A5);
        chk("b2b_word1", 32'(word_from(0, 8)), 32'h0000_003C);
        chk("b2b_word1_msb", 32'(word_from(1, 8)), 32'h0000_003C);

        // Backpressure at cnt 4 of F0
        clear_stats();
        send(8'hF0);
        repeat (4) @(posedge clk);
        #1 ser_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_sel", c), 32'(d_sel[0]), 4);
            chk($sformatf("stall%0d_bit", c), 32'(d_ser_bit[0]), 1);
            chk($sformatf("stall%0d_valid", c), 32'(d_ser_valid[0]), 1);
        end
        @(posedge clk); #1 ser_ready = 1'b1;
        wait_idle();
        chk("stall_beats", nb[0], 8);
        chk("stall_valid_cycles", vcount[0], 11);
        chk("stall_word", 32'(word_from(0, 0)), 32'h0000_00F0);

        // MSB-first order on 81
        clear_stats();
        send(8'h81);
        wait_idle();
        chk("m81_beats", nb[1], 8);
        for (int j = 0; j < 8; j++) chk($sformatf("m81_sel%0d", j), 32'(ss[1][j]), 7 - j);
        chk("m81_stream", 32'(sb[1][7:0]), 32'h0000_0081);

        // Reset mid-frame at cnt 3 of FF, then clean word 01
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(d_ser_valid[0]), 0);
        chk("midrst_busy", 32'(d_busy[0]), 0);
        chk("midrst_sel_msb", 32'(d_sel[1]), 7);
        clear_stats();
        send(8'h01);
        wait_idle();
        chk("post_beats", nb[0], 8);
        chk("post_first_bit", 32'(sb[0][0]), 1);
        chk("post_word", 32'(word_from(0, 0)), 32'h0000_0001);
        chk("post_word_msb", 32'(word_from(1, 0)), 32'h0000_0001);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer_8b.md
Name: piso_serializer_8b

Overview:
Parallel-in/serial-out stage feeding an 8:1 bit-select datapath. It accepts an 8-bit word over a valid/ready handshake and holds it in a register. It then steps a 3-bit select index through all eight positions, presenting one bit per accepted beat with valid/ready flow control and first/last framing. Back-to-back words stream without bubbles.

Parameters:
DATA_W, 8, word width; fixed at 8 in this revision, with the index width SEL_W = 3 derived from it.
LSB_FIRST, 1, 1: index runs 0->7 (bit 0 first); 0: index runs 7->0 (bit 7 first).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  8  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
ser_bit  output  1  currently selected bit, equal to word_q[sel]
ser_valid  output  1  ser_bit is valid
ser_ready  input  1  downstream accepts ser_bit this cycle
ser_first  output  1  ser_bit is the first bit of the word
ser_last  output  1  ser_bit is the last bit of the word
sel  output  3  current bit index driven into the select datapath
busy  output  1  a word is held and not fully shifted out

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk.
- Reset values:
  - state = IDLE, word_q = 8'h00, bit count cnt = 0.
  - sel = 0 if LSB_FIRST, else 7.
  - ser_valid = 0, ser_first = 0, ser_last = 0, busy = 0.
  - in_ready reads 0 while rst is high.
- States:
  - IDLE: ser_valid = 0, in_ready = 1.
  - SHIFT: ser_valid = 1.
- Input accept: occurs when in_valid & in_ready. On accept:
  - word_q <= in_data, cnt <= 0, sel <= start index, state <= SHIFT.
- Latency: a word accepted on edge N presents its first bit with ser_valid = 1 in the cycle after edge N.
- Output beat: occurs when ser_valid & ser_ready. On a beat:
  - if cnt < 7: cnt <= cnt + 1, and sel steps +1 (LSB_FIRST) or -1 (MSB first).
  - if cnt == 7: the word is complete.
- Framing:
  - ser_first = ser_valid & (cnt == 0).
  - ser_last = ser_valid & (cnt == 7).
  - busy = (state == SHIFT).
- ser_bit = word_q[sel]. It is combinational from registered values only and has no path from in_data.
- in_ready = (state == IDLE) | (state == SHIFT & cnt == 7 & ser_ready).
  - If the last beat and an accept coincide, the new word loads and SHIFT continues with cnt = 0, giving zero bubble.
  - If the last beat happens with no accept, state <= IDLE.
- Stall: while ser_valid & !ser_ready, ser_bit, sel, cnt, ser_first, ser_last and word_q are all held stable.
- In SHIFT with cnt < 7, in_valid is ignored (in_ready = 0). The held word is never overwritten mid-frame.
- Index wrap: sel never wraps within a word. It is reloaded to the start index only on accept or reset.
- Reset mid-frame: the frame is abandoned with no partial completion. Outputs return to reset values on the next edge.
- ser_ready is ignored in IDLE.

Decomposition:
- Shared package piso_pkg:
  - SEL_W = 3, BITS_PER_WORD = 8, LAST_CNT = 3'd7.
  - State encoding IDLE = 1'b0, SHIFT = 1'b1.
  - Start-index constants for both orders.
- One natural sub-module: piso_index_ctr.
  - Contents: cnt, sel up/down step and load-on-accept, generation of first/last.
  - Top level keeps the word register, the FSM and the ready logic.

Test Plan:
- Reset, then check quiescent outputs -> during rst: in_ready = 0, ser_valid = 0, busy = 0. After release: in_ready = 1, sel = 0.
- LSB_FIRST = 1, accept 8'hA5, ser_ready held 1 -> 8 consecutive beats with ser_bit = 1,0,1,0,0,1,0,1 and sel = 0..7. ser_first on beat 1, ser_last on beat 8, then busy = 0.
- Back-to-back words 8'hA5 then 8'h3C, in_valid held high -> 16 consecutive ser_valid cycles with no gap. in_ready pulses only on the beat with ser_last; the second frame starts the next cycle with ser_first = 1.
- Backpressure: word 8'hF0, ser_ready low for 3 cycles at cnt = 4 -> ser_bit = 1, sel = 4 and cnt held for all 3 cycles. Completion is delayed exactly 3 cycles, and no bit is lost or duplicated.
- LSB_FIRST = 0, word 8'h81 -> sel = 7..0, ser_bit = 1,0,0,0,0,0,0,1.
- Assert rst at cnt = 3 of word 8'hFF -> next cycle ser_valid = 0 and busy = 0. A new word 8'h01 is then accepted and serializes cleanly from bit 0.
